apb_master_arbiter: RTL and testbench

Two-requester APB master that shares one 8-bit APB bus (timer / interrupt-handler register file) between two on-chip initiators, e.g. the CPU-side config port and a DMA/autoload engine. Each requester issues single read or write transfers over a valid/grant/done interface. The block arbitrates round-robin, sequences the APB SETUP/ACCESS phases, honours pready wait states, returns prdata/pslverr, and aborts hung transfers on a timeout.

---
 rtl/apb_arb_pkg.sv | 14 +
 rtl/apb_master_arbiter_if.sv | 35 +++
 rtl/apb_rr_pick.sv | 14 +
 rtl/apb_master_arbiter.sv | 113 +++++++++++
 tb/tb_apb_master_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types for the two-requester APB master: FSM encoding, default timeout, requester index.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  localparam int TIMEOUT_DEF = 16;

  typedef logic req_idx_t;

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Requester handshakes plus the shared APB bus; master = arbiter view, slave = environment view.
interface apb_master_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req0_valid, req0_write, req0_gnt, req0_done, req0_err;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata, req0_rdata;

  logic              req1_valid, req1_write, req1_gnt, req1_done, req1_err;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata, req1_rdata;

  logic              psel, penable, pwrite, pready, pslverr;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata, prdata;

  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req0_gnt, req0_done, req0_rdata, req0_err,
    output req1_gnt, req1_done, req1_rdata, req1_err,
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req0_gnt, req0_done, req0_rdata, req0_err,
    input  req1_gnt, req1_done, req1_rdata, req1_err,
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_rr_pick.sv
// Combinational 2-way round-robin pick: on a tie the requester that did not win last time goes.
module apb_rr_pick
  import apb_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  req_idx_t   last_gnt,
  output req_idx_t   gnt_idx,
  output logic       any
);
  always_comb begin
    any     = |valid;
    gnt_idx = valid[1] & (~valid[0] | ~last_gnt);
  end
endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB bus between two requesters: round-robin grant, SETUP/ACCESS sequencing,
// pready wait states and a timeout abort. Every output is registered.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
) (
  input  logic                 pclk,
  input  logic                 preset_n,
  apb_master_arbiter_if.master bus
);
  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] SETUP  = ST_SETUP;
  localparam logic [1:0] ACCESS = ST_ACCESS;
  localparam int         CNT_W  = $clog2(TIMEOUT + 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  req_idx_t         last_gnt, owner, pick_idx;
  logic             pick_any;

  apb_rr_pick u_pick (
    .valid    ({bus.req1_valid, bus.req0_valid}),
    .last_gnt (last_gnt),
    .gnt_idx  (pick_idx),
    .any      (pick_any)
  );

  logic              nxt_write, finish, timed_out, start, fin_err;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] nxt_wdata, fin_rdata;

  always_comb begin
    nxt_write = pick_idx ? bus.req1_write : bus.req0_write;
    nxt_addr  = pick_idx ? bus.req1_addr  : bus.req0_addr;
    nxt_wdata = pick_idx ? bus.req1_wdata : bus.req0_wdata;
    timed_out = !bus.pready;
    finish    = (state == ACCESS) && (bus.pready || (wait_cnt == CNT_W'(TIMEOUT - 1)));
    // A completing transfer can hand the bus straight to the next winner without visiting IDLE.
    start     = pick_any && ((state == IDLE) || finish);
    fin_err   = timed_out || bus.pslverr;
    fin_rdata = (timed_out || bus.pwrite) ? '0 : bus.prdata;
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      last_gnt       <= 1'b1;
      owner          <= 1'b0;
      bus.psel       <= 1'b0;
      bus.penable    <= 1'b0;
      bus.pwrite     <= 1'b0;
      bus.paddr      <= '0;
      bus.pwdata     <= '0;
      bus.req0_gnt   <= 1'b0;
      bus.req1_gnt   <= 1'b0;
      bus.req0_done  <= 1'b0;
      bus.req1_done  <= 1'b0;
      bus.req0_rdata <= '0;
      bus.req1_rdata <= '0;
      bus.req0_err   <= 1'b0;
      bus.req1_err   <= 1'b0;
    end else begin
      bus.req0_gnt  <= start && !pick_idx;
      bus.req1_gnt  <= start &&  pick_idx;
      bus.req0_done <= finish && !owner;
      bus.req1_done <= finish &&  owner;

      if (finish && !owner) begin
        bus.req0_rdata <= fin_rdata;
        bus.req0_err   <= fin_err;
      end
      if (finish && owner) begin
        bus.req1_rdata <= fin_rdata;
        bus.req1_err   <= fin_err;
      end

      case (state)
        SETUP: begin
          bus.penable <= 1'b1;
          wait_cnt    <= '0;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (finish) bus.penable <= 1'b0;
          else        wait_cnt    <= wait_cnt + 1'b1;
        end
        default: ;
      endcase

      if (start) begin
        bus.psel   <= 1'b1;
        bus.pwrite <= nxt_write;
        bus.paddr  <= nxt_addr;
        bus.pwdata <= nxt_wdata;
        owner      <= pick_idx;
        last_gnt   <= pick_idx;
        state      <= SETUP;
      end else if (finish) begin
        bus.psel   <= 1'b0;
        bus.pwrite <= 1'b0;
        bus.paddr  <= '0;
        bus.pwdata <= '0;
        state      <= IDLE;
      end else if (state != IDLE && state != SETUP && state != ACCESS) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: hand-computed expectations sampled on the falling edge.
module tb_apb_master_arbiter;
  logic pclk;
  logic preset_n;
  int   n_chk = 0;
  int   n_bad = 0;

  apb_master_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  apb_master_arbiter #(.TIMEOUT(16), .ADDR_W(8), .DATA_W(8)) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .bus      (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic idle_reqs();
    bus.req0_valid = 0; bus.req0_write = 0; bus.req0_addr = 0; bus.req0_wdata = 0;
    bus.req1_valid = 0; bus.req1_write = 0; bus.req1_addr = 0; bus.req1_wdata = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gcount, prev_cyc, idx, n_to;
    bit found;
    int cnt_g [2];

    idle_reqs();
    bus.pready = 1; bus.pslverr = 0; bus.prdata = 0;
    preset_n = 0;
    tick(); tick();
    chk("rst_psel", bus.psel, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_gnt", {bus.req0_gnt, bus.req1_gnt}, 0);
    chk("rst_done", {bus.req0_done, bus.req1_done}, 0);
    preset_n = 1;
    tick();

    // single write
    bus.req0_valid = 1; bus.req0_write = 1; bus.req0_addr = 8'h04; bus.req0_wdata = 8'hA5;
    tick();
    chk("wr_gnt0", bus.req0_gnt, 1);
    chk("wr_psel_setup", bus.psel, 1);
    chk("wr_penable_setup", bus.penable, 0);
    chk("wr_paddr", bus.paddr, 8'h04);
    chk("wr_pwdata", bus.pwdata, 8'hA5);
    chk("wr_pwrite", bus.pwrite, 1);
    idle_reqs();
    tick();
    chk("wr_penable_access", bus.penable, 1);
    chk("wr_gnt0_pulse", bus.req0_gnt, 0);
    chk("wr_pwdata_hold", bus.pwdata, 8'hA5);
    tick();
    chk("wr_done0", bus.req0_done, 1);
    chk("wr_err0", bus.req0_err, 0);
    chk("wr_rdata0", bus.req0_rdata, 0);
    chk("wr_psel_end", bus.psel, 0);
    chk("wr_paddr_end", bus.paddr, 0);
    tick();
    chk("wr_done0_pulse", bus.req0_done, 0);

    // read with 3 wait states
    bus.pready = 0;
    bus.req1_valid = 1; bus.req1_write = 0; bus.req1_addr = 8'h08;
    tick();
    chk("rd_gnt1", bus.req1_gnt, 1);
    chk("rd_pwrite", bus.pwrite, 0);
    idle_reqs();
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rd_wait_nodone", bus.req1_done, 0);
      chk("rd_wait_penable", bus.penable, 1);
    end
    bus.pready = 1; bus.prdata = 8'h3C;
    tick();
    chk("rd_done1", bus.req1_done, 1);
    chk("rd_rdata1", bus.req1_rdata, 8'h3C);
    chk("rd_err1", bus.req1_err, 0);
    bus.prdata = 8'h77;
    tick();

    // contention: both requesters hold valid for four reads each
    bus.req0_valid = 1; bus.req0_addr = 8'h10;
    bus.req1_valid = 1; bus.req1_addr = 8'h11;
    cnt_g[0] = 0; cnt_g[1] = 0;
    gcount = 0; prev_cyc = 0;
    for (int cyc = 0; cyc < 40 && gcount < 8; cyc++) begin
      tick();
      if (gcount > 0) chk("rr_psel_held", bus.psel, 1);
      if (bus.req0_gnt || bus.req1_gnt) begin
        chk("rr_one_gnt", bus.req0_gnt & bus.req1_gnt, 0);
        idx = bus.req1_gnt ? 1 : 0;
        chk("rr_order", idx, gcount % 2);
        if (gcount > 0) chk("rr_spacing", cyc - prev_cyc, 2);
        prev_cyc = cyc;
        gcount++;
        cnt_g[idx]++;
        if (cnt_g[idx] == 4) begin
          if (idx == 0) bus.req0_valid = 0;
          else          bus.req1_valid = 0;
        end
      end
    end
    chk("rr_grants", gcount, 8);
    tick(); tick();
    chk("rr_last_done1", bus.req1_done, 1);
    chk("rr_psel_idle", bus.psel, 0);
    idle_reqs();
    tick();

    // slave error on 8'hFF
    bus.pslverr = 1;
    bus.req0_valid = 1; bus.req0_write = 1; bus.req0_addr = 8'hFF; bus.req0_wdata = 8'h55;
    tick();
    chk("err_gnt0", bus.req0_gnt, 1);
    idle_reqs();
    tick(); tick();
    chk("err_done0", bus.req0_done, 1);
    chk("err_err0", bus.req0_err, 1);
    chk("err_other_err", bus.req1_err, 0);
    chk("err_other_rdata", bus.req1_rdata, 8'h77);
    bus.pslverr = 0;
    tick();

    // timeout with pready stuck low
    bus.pready = 0;
    bus.req1_valid = 1; bus.req1_addr = 8'h20;
    tick();
    chk("to_gnt1", bus.req1_gnt, 1);
    idle_reqs();
    tick();
    chk("to_penable", bus.penable, 1);
    found = 0; n_to = 0;
    for (int n = 1; n <= 24 && !found; n++) begin
      tick();
      if (bus.req1_done) begin
        found = 1;
        n_to = n;
      end
    end
    chk("to_latency", n_to, 16);
    chk("to_err1", bus.req1_err, 1);
    chk("to_rdata1", bus.req1_rdata, 0);
    chk("to_psel_idle", bus.psel, 0);
    chk("to_penable_idle", bus.penable, 0);
    chk("to_err0_held", bus.req0_err, 1);
    tick();

    // reset in the middle of ACCESS
    bus.req0_valid = 1; bus.req0_write = 0; bus.req0_addr = 8'h30;
    tick();
    idle_reqs();
    tick(); tick();
    chk("rst_mid_psel_before", bus.psel, 1);
    #2 preset_n = 0;
    #1;
    chk("rst_mid_psel", bus.psel, 0);
    chk("rst_mid_penable", bus.penable, 0);
    chk("rst_mid_paddr", bus.paddr, 0);
    chk("rst_mid_err", {bus.req0_err, bus.req1_err}, 0);
    chk("rst_mid_rdata", bus.req1_rdata, 0);
    tick();
    chk("rst_mid_nodone", {bus.req0_done, bus.req1_done}, 0);
    tick();
    preset_n = 1;
    bus.pready = 1; bus.prdata = 8'h5A;
    bus.req0_valid = 1; bus.req0_addr = 8'h30;
    bus.req1_valid = 1; bus.req1_addr = 8'h31;
    tick();
    chk("post_rst_gnt0", bus.req0_gnt, 1);
    chk("post_rst_gnt1", bus.req1_gnt, 0);
    chk("post_rst_paddr", bus.paddr, 8'h30);
    bus.req0_valid = 0;
    tick(); tick();
    chk("post_rst_done0", bus.req0_done, 1);
    chk("post_rst_rdata0", bus.req0_rdata, 8'h5A);
    chk("post_rst_gnt1_next", bus.req1_gnt, 1);
    idle_reqs();
    tick(); tick();
    chk("post_rst_done1", bus.req1_done, 1);
    chk("post_rst_idle", bus.psel, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
